// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the 5-stage RISC-V pipeline: hazard FSM states,
// architectural constants and default datapath width.
package riscv_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_AW       = 5;

  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  typedef enum logic [0:0] {
    StRun,
    StMemHold
  } hazard_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator between the ID-stage sources and the load in ID/EX.
// Shared with the forwarding unit.
module pipe_hazard_detect
  import riscv_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_ren,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
  assign rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_ren && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_mem_ren,
  input  logic                  ex_redirect,
  input  logic [XLEN-1:0]       ex_target,
  input  logic                  icache_stall,
  input  logic                  dcache_stall,
  output logic                  stall_if,
  output logic                  flush_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_luse_cnt,
  output logic [PERF_W-1:0]     perf_dstall_cnt,
  output logic [PERF_W-1:0]     perf_redir_cnt
`endif
);

  hazard_state_e   state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic load_use;
  logic run_eval;
  logic win_luse;
  logic win_dstall;

  pipe_hazard_detect u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_mem_ren (ex_mem_ren),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    stall_if       = 1'b0;
    flush_if       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    run_eval       = 1'b0;
    win_luse       = 1'b0;
    win_dstall     = 1'b0;

    unique case (state_q)
      StRun: run_eval = 1'b1;
      StMemHold: begin
        if (dcache_stall) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          stall_mem  = 1'b1;
          win_dstall = 1'b1;
          // EX is frozen, so repeated pulses are the same instruction; keep the first.
          if (ex_redirect && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = ex_target;
          end
        end else if (pend_valid_q) begin
          redirect_valid = 1'b1;
          redirect_pc    = pend_pc_q;
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          pend_valid_d   = 1'b0;
          state_d        = StRun;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    if (run_eval) begin
      state_d = StRun;
      if (dcache_stall) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        stall_ex   = 1'b1;
        stall_mem  = 1'b1;
        win_dstall = 1'b1;
        state_d    = StMemHold;
        if (ex_redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = ex_target;
        end
      end else if (ex_redirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_target;
        flush_if       = 1'b1;
        flush_id       = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
        win_luse = 1'b1;
      end else if (icache_stall) begin
        stall_if = 1'b1;
        flush_if = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] luse_cnt_q, dstall_cnt_q, redir_cnt_q;

  // Saturating counters: stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luse_cnt_q   <= '0;
      dstall_cnt_q <= '0;
      redir_cnt_q  <= '0;
    end else begin
      if (win_luse && (luse_cnt_q != '1)) begin
        luse_cnt_q <= luse_cnt_q + 1'b1;
      end
      if (win_dstall && (dstall_cnt_q != '1)) begin
        dstall_cnt_q <= dstall_cnt_q + 1'b1;
      end
      if (redirect_valid && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + 1'b1;
      end
    end
  end

  assign perf_luse_cnt   = luse_cnt_q;
  assign perf_dstall_cnt = dstall_cnt_q;
  assign perf_redir_cnt  = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; covers counters when
// HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PERF_W = 32;

  // Control bit order: {stall_if, flush_if, stall_id, flush_id, stall_ex, stall_mem, redirect_valid}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LUSE  = 7'b1001000;
  localparam logic [6:0] C_REDIR = 7'b0101001;
  localparam logic [6:0] C_DSTL  = 7'b1010110;
  localparam logic [6:0] C_ICACH = 7'b1100000;

  logic            clk;
  logic            rst_n;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_mem_ren;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            icache_stall, dcache_stall;
  logic            stall_if, flush_if, stall_id, flush_id, stall_ex, stall_mem;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_luse_cnt, perf_dstall_cnt, perf_redir_cnt;
`endif

  int vectors;
  int miscompares;

  pipe_hazard_ctrl #(
    .XLEN   (XLEN),
    .PERF_W (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_ren     (ex_mem_ren),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .stall_if       (stall_if),
    .flush_if       (flush_if),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_luse_cnt   (perf_luse_cnt),
    .perf_dstall_cnt (perf_dstall_cnt),
    .perf_redir_cnt  (perf_redir_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {stall_if, flush_if, stall_id, flush_id, stall_ex, stall_mem, redirect_valid};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [6:0] exp_ctl,
                           input logic [XLEN-1:0] exp_pc);
    #1;
    check({tag, ".ctl"}, {25'd0, ctl()}, {25'd0, exp_ctl});
    check({tag, ".pc"}, redirect_pc, exp_pc);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_mem_ren = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    icache_stall = 1'b0; dcache_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    rst_n = 1'b0;
    check_out("reset", C_NONE, '0);
    #10 rst_n = 1'b1;
    tick();

    // Load-use on rs1: one bubble, then clear once the load moves on.
    ex_mem_ren = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    check_out("luse_rs1", C_LUSE, '0);
    tick();
    idle();
    check_out("luse_after", C_NONE, '0);
    tick();

    // Redirect beats load-use and icache stall.
    ex_mem_ren = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    icache_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0100;
    check_out("redir_prio", C_REDIR, 32'h100);
    tick();
    idle();

    // Redirect during dcache stall is held and released once.
    dcache_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h200;
    check_out("dstall1", C_DSTL, '0);
    tick();
    ex_target = 32'h300;
    check_out("dstall2", C_DSTL, '0);
    tick();
    check_out("dstall3", C_DSTL, '0);
    tick();
    dcache_stall = 1'b0;
    check_out("dstall_rel", C_REDIR, 32'h200);
    tick();
    idle();
    check_out("dstall_post", C_NONE, '0);

`ifdef HAZARD_PERF_CNT_EN
    check("perf_luse", perf_luse_cnt, 32'd1);
    check("perf_redir", perf_redir_cnt, 32'd2);
    check("perf_dstall", perf_dstall_cnt, 32'd3);
`endif
    tick();

    // x0 destination never hazards.
    ex_mem_ren = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    check_out("x0", C_NONE, '0);
    tick();
    // Matching registers but source not read.
    ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    check_out("nouse", C_NONE, '0);
    tick();
    idle();
    icache_stall = 1'b1;
    check_out("icache", C_ICACH, '0);
    tick();
    idle();

    // Stall release without pending falls through to RUN priorities.
    dcache_stall = 1'b1;
    check_out("dstall_np", C_DSTL, '0);
    tick();
    dcache_stall = 1'b0; ex_mem_ren = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    check_out("dstall_np_rel", C_LUSE, '0);
    tick();
    idle();

    // Asynchronous reset after a redirect has been latched drops it.
    dcache_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h400;
    tick();
    ex_redirect = 1'b0;
    check_out("rst_hold", C_DSTL, '0);
    dcache_stall = 1'b0;
    rst_n = 1'b0;
    check_out("rst_async", C_NONE, '0);
    #1 rst_n = 1'b1;
    check_out("rst_rel", C_NONE, '0);
    tick();
    check_out("rst_after", C_NONE, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
